axi_ar_allocator: RTL and testbench

AXI_AR_ALLOCATOR -- requirements
Module: axi_ar_allocator

---
 rtl/axi_ar_allocator.sv | 134 +++++++++++++
 tb/tb_axi_ar_allocator.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_allocator.sv
// Round-robin allocator for N AR requesters onto one address channel,
// with a cap on accepted-but-uncompleted read bursts.
module axi_ar_allocator #(
    parameter int N_TARG_PORT     = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int LOG_N          = $clog2(N_TARG_PORT),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_TARG_PORT-1:0]          arvalid_i,
    output logic [N_TARG_PORT-1:0]          arready_o,
    input  logic [N_TARG_PORT*ADDR_WIDTH-1:0] araddr_i,
    input  logic [N_TARG_PORT*ID_WIDTH-1:0] arid_i,
    input  logic [N_TARG_PORT*8-1:0]        arlen_i,
    output logic                            arvalid_o,
    input  logic                            arready_i,
    output logic [ADDR_WIDTH-1:0]           araddr_o,
    output logic [7:0]                      arlen_o,
    output logic [LOG_N+ID_WIDTH-1:0]       arid_o,
    input  logic                            rdone_i,
    output logic [CNT_W-1:0]                outstanding_o,
    output logic                            full_o,
    output logic                            underflow_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [LOG_N-1:0] LAST    = LOG_N'(N_TARG_PORT - 1);

    state_t           state, state_nxt;
    logic [LOG_N-1:0] gnt, gnt_nxt;
    logic [LOG_N-1:0] rr_ptr, rr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             uf, uf_nxt;
    logic [LOG_N-1:0] pick;
    logic             any_req;
    logic             gnt_valid;
    logic             hs;
    int unsigned      idx;

    // First requesting port at or after rr_ptr, wrapping past the last port.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= N_TARG_PORT) idx = idx - N_TARG_PORT;
            if (!any_req && arvalid_i[LOG_N'(idx)]) begin
                any_req = 1'b1;
                pick    = LOG_N'(idx);
            end
        end
    end

    always_comb begin
        araddr_o = '0;
        arlen_o  = '0;
        arid_o   = '0;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            if (LOG_N'(i) == gnt) begin
                araddr_o = araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                arlen_o  = arlen_i[i*8 +: 8];
                arid_o   = {gnt, arid_i[i*ID_WIDTH +: ID_WIDTH]};
            end
        end
    end

    assign full_o        = (cnt == MAX_CNT);
    assign outstanding_o = cnt;
    assign underflow_o   = uf;
    assign gnt_valid     = (state == LOCKED) && arvalid_i[gnt];
    assign hs            = gnt_valid && arready_i;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr_ptr;
        arvalid_o = 1'b0;
        arready_o = '0;
        case (state)
            IDLE: begin
                if (any_req && !full_o) begin
                    gnt_nxt   = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                arvalid_o      = gnt_valid;
                arready_o[gnt] = arready_i;
                if (!arvalid_i[gnt]) begin
                    state_nxt = IDLE;
                end else if (arready_i) begin
                    state_nxt = IDLE;
                    rr_nxt    = (gnt == LAST) ? '0 : gnt + LOG_N'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A handshake and a completion in the same cycle cancel out.
    always_comb begin
        cnt_nxt = cnt;
        uf_nxt  = uf;
        if (hs && !rdone_i) begin
            if (cnt != MAX_CNT) cnt_nxt = cnt + CNT_W'(1);
        end else if (!hs && rdone_i) begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else           uf_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            uf     <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
            uf     <= uf_nxt;
        end
    end

endmodule

// File: tb/tb_axi_ar_allocator.sv
// Bench for axi_ar_allocator: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_axi_ar_allocator;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int MAXO = 8;
    localparam int LN   = 2;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    arvalid_i;
    logic [N-1:0]    arready_o;
    logic [N*AW-1:0] araddr_i;
    logic [N*IW-1:0] arid_i;
    logic [N*8-1:0]  arlen_i;
    logic            arvalid_o;
    logic            arready_i;
    logic [AW-1:0]   araddr_o;
    logic [7:0]      arlen_o;
    logic [LN+IW-1:0] arid_o;
    logic            rdone_i;
    logic [CW-1:0]   outstanding_o;
    logic            full_o;
    logic            underflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-grant view of the allocator.
    bit m_locked;
    int m_gnt, m_rr, m_cnt;
    bit m_uf;

    axi_ar_allocator #(
        .N_TARG_PORT(N), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .arvalid_i(arvalid_i), .arready_o(arready_o),
        .araddr_i(araddr_i), .arid_i(arid_i), .arlen_i(arlen_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arid_o(arid_o),
        .rdone_i(rdone_i), .outstanding_o(outstanding_o),
        .full_o(full_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    // Advance the model with the inputs currently applied, then move to the next negedge.
    task automatic tick();
        bit hs;
        int old_cnt;
        hs = m_locked && arvalid_i[m_gnt] && arready_i;
        if (rst) begin
            m_locked = 0; m_gnt = 0; m_rr = 0; m_cnt = 0; m_uf = 0;
        end else begin
            old_cnt = m_cnt;
            if (hs && !rdone_i) m_cnt = m_cnt + 1;
            else if (!hs && rdone_i) begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else m_uf = 1;
            end
            if (!m_locked) begin
                if (arvalid_i != 0 && old_cnt < MAXO) begin
                    for (int k = 0; k < N; k++) begin
                        if (arvalid_i[(m_rr + k) % N]) begin
                            m_gnt = (m_rr + k) % N;
                            m_locked = 1;
                            break;
                        end
                    end
                end
            end else if (!arvalid_i[m_gnt]) begin
                m_locked = 0;
            end else if (arready_i) begin
                m_locked = 0;
                m_rr = (m_gnt + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1; arvalid_i = '1; arready_i = 1'b1;
        tick();
        #1;
        checks++;
        if ({arvalid_o, arready_o, outstanding_o, full_o, underflow_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got arvalid=%b arready=%b cnt=%0d full=%b uf=%b, want all 0",
                     arvalid_o, arready_o, outstanding_o, full_o, underflow_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] want_g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            araddr_i[i*AW +: AW] = 32'h1000_0000 + 32'(i);
            arid_i[i*IW +: IW]   = IW'(i + 5);
        end
        arvalid_i = '1; arready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (arvalid_o !== 1'((c % 2) == 1)) begin
                errors++;
                $display("FAIL rr_valid c=%0d: got %b want %b", c, arvalid_o, (c % 2) == 1);
            end
            checks++;
            if (outstanding_o !== CW'(c / 2)) begin
                errors++;
                $display("FAIL rr_cnt c=%0d: got %0d want %0d", c, outstanding_o, c / 2);
            end
            if (c % 2 == 1) begin
                want_g = 2'(((c - 1) / 2) % 4);
                checks++;
                if (arid_o[5:4] !== want_g || araddr_o !== 32'h1000_0000 + 32'(want_g)) begin
                    errors++;
                    $display("FAIL rr_grant c=%0d: got id=%h addr=%h want grant %0d", c, arid_o, araddr_o, want_g);
                end
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        arid_i[2*IW +: IW] = 4'hA;
        arvalid_i = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) arvalid_i = 4'b0110;
            arready_i = (c == 4);
            #1;
            checks++;
            if (arvalid_o !== 1'(c >= 1 && c <= 4) || (c >= 1 && c <= 4 && arid_o !== 6'h2A)) begin
                errors++;
                $display("FAIL stall c=%0d: got valid=%b id=%h want valid=%b id=2a", c, arvalid_o, arid_o, c >= 1 && c <= 4);
            end
            checks++;
            if (arready_o !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL stall_ready c=%0d: got %b", c, arready_o);
            end
            tick();
        end
        #1;
        checks++;
        if (outstanding_o !== CW'(1)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 1", outstanding_o);
        end
        quiet();
        tick();
    endtask

    task automatic test_full();
        do_reset();
        arvalid_i = '1; arready_i = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        for (int c = 16; c < 23; c++) begin
            rdone_i = (c == 20);
            #1;
            checks++;
            if (c < 21 && (full_o !== 1'b1 || arvalid_o !== 1'b0 || outstanding_o !== CW'(8))) begin
                errors++;
                $display("FAIL full_hold c=%0d: got full=%b valid=%b cnt=%0d want 1 0 8", c, full_o, arvalid_o, outstanding_o);
            end
            if (c == 21 && (full_o !== 1'b0 || arvalid_o !== 1'b0 || outstanding_o !== CW'(7))) begin
                errors++;
                $display("FAIL full_release: got full=%b valid=%b cnt=%0d want 0 0 7", full_o, arvalid_o, outstanding_o);
            end
            if (c == 22 && arvalid_o !== 1'b1) begin
                errors++;
                $display("FAIL full_regrant: got valid=%b want 1", arvalid_o);
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_concurrent_and_underflow();
        do_reset();
        arvalid_i = 4'b0001; arready_i = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        for (int c = 6; c < 16; c++) begin
            rdone_i   = (c >= 7 && c <= 11);
            arvalid_i = (c <= 7) ? 4'b0001 : 4'b0000;
            rst       = (c == 15);
            #1;
            checks++;
            if (c <= 8 && (outstanding_o !== CW'(3) || (c == 7 && arvalid_o !== 1'b1))) begin
                errors++;
                $display("FAIL concurrent c=%0d: got cnt=%0d valid=%b want cnt 3", c, outstanding_o, arvalid_o);
            end
            if (c >= 9 && c <= 11 && outstanding_o !== CW'(11 - c)) begin
                errors++;
                $display("FAIL drain c=%0d: got %0d want %0d", c, outstanding_o, 11 - c);
            end
            if (c >= 12 && (underflow_o !== 1'b1 || outstanding_o !== '0)) begin
                errors++;
                $display("FAIL underflow c=%0d: got uf=%b cnt=%0d want 1 0", c, underflow_o, outstanding_o);
            end
            if (c == 11 && underflow_o !== 1'b0) begin
                errors++;
                $display("FAIL underflow_early: got %b want 0", underflow_o);
            end
            tick();
        end
        #1;
        checks++;
        if (underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b want 0", underflow_o);
        end
        quiet();
    endtask

    task automatic test_drop();
        do_reset();
        arvalid_i = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) arvalid_i = 4'b0000;
            if (c == 3) arvalid_i = 4'b0110;
            #1;
            checks++;
            if (arvalid_o !== 1'(c == 1 || c == 4) || outstanding_o !== '0) begin
                errors++;
                $display("FAIL drop c=%0d: got valid=%b cnt=%0d", c, arvalid_o, outstanding_o);
            end
            if (c == 4) begin
                checks++;
                if (arid_o[5:4] !== 2'd1) begin
                    errors++;
                    $display("FAIL drop_rr: got grant %0d want 1", arid_o[5:4]);
                end
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_reset_locked();
        do_reset();
        arvalid_i = 4'b0100; arready_i = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        arready_i = 1'b0;
        tick();
        #1;
        checks++;
        if (arvalid_o !== 1'b1 || outstanding_o !== CW'(5)) begin
            errors++;
            $display("FAIL pre_reset: got valid=%b cnt=%0d want 1 5", arvalid_o, outstanding_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; arvalid_i = 4'b1001;
        #1;
        checks++;
        if (arvalid_o !== 1'b0 || outstanding_o !== '0) begin
            errors++;
            $display("FAIL reset_locked: got valid=%b cnt=%0d want 0 0", arvalid_o, outstanding_o);
        end
        tick();
        #1;
        checks++;
        if (arvalid_o !== 1'b1 || arid_o[5:4] !== 2'd0) begin
            errors++;
            $display("FAIL reset_rr: got valid=%b grant=%0d want 1 0", arvalid_o, arid_o[5:4]);
        end
        quiet();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]     e_ready;
        logic             e_valid;
        logic [LN+IW-1:0] e_id;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                araddr_i[i*AW +: AW] = $urandom;
                arid_i[i*IW +: IW]   = IW'($urandom);
                arlen_i[i*8 +: 8]    = 8'($urandom);
            end
            arvalid_i = N'($urandom);
            arready_i = 1'($urandom);
            rdone_i   = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            #1;
            e_valid = m_locked && arvalid_i[m_gnt];
            e_ready = m_locked ? (N'(arready_i) << m_gnt) : '0;
            checks++;
            if (arvalid_o !== e_valid || arready_o !== e_ready) begin
                errors++;
                $display("FAIL rand_hs c=%0d: got valid=%b ready=%b want %b %b", c, arvalid_o, arready_o, e_valid, e_ready);
            end
            checks++;
            if (outstanding_o !== CW'(m_cnt) || full_o !== (m_cnt == MAXO) || underflow_o !== m_uf) begin
                errors++;
                $display("FAIL rand_cnt c=%0d: got cnt=%0d full=%b uf=%b want %0d %b %b",
                         c, outstanding_o, full_o, underflow_o, m_cnt, m_cnt == MAXO, m_uf);
            end
            if (e_valid) begin
                e_id = {LN'(m_gnt), arid_i[m_gnt*IW +: IW]};
                checks++;
                if (araddr_o !== araddr_i[m_gnt*AW +: AW] || arlen_o !== arlen_i[m_gnt*8 +: 8] || arid_o !== e_id) begin
                    errors++;
                    $display("FAIL rand_payload c=%0d: got addr=%h len=%h id=%h want %h %h %h", c, araddr_o, arlen_o,
                             arid_o, araddr_i[m_gnt*AW +: AW], arlen_i[m_gnt*8 +: 8], e_id);
                end
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        araddr_i = '0; arid_i = '0; arlen_i = '0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_stall();
        test_full();
        test_concurrent_and_underflow();
        test_drop();
        test_reset_locked();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
